// File: rtl/seq_detect_param.sv
// seq_detect_param: parameterised serial pattern detector with
// runtime pattern load, match counter and optional sticky lock.
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   X, EN     serial data bit and its sample enable
//   PAT_LD    load PAT_IN as the active pattern (wins over EN)
//   PAT_IN    runtime pattern, MSB is the first bit received
//   Z         registered one-cycle match pulse (held 1 when locked)
//   LOCK      sticky lock flag
//   MATCH_CNT saturating count of matches since reset
//   state     FSM state: IDLE=00 FILL=01 RUN=10 LOCKED=11
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               LOCK_N  = 0,
    parameter int               CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             X,
    input  logic             EN,
    input  logic             PAT_LD,
    input  logic [PAT_W-1:0] PAT_IN,
    output logic             Z,
    output logic             LOCK,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [1:0]       state
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CMAX    = '1;
    localparam logic [CNT_W-1:0] LOCK_AT = CNT_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FILL   = 2'b01,
        RUN    = 2'b10,
        LOCKED = 2'b11
    } st_t;

    st_t              st_q, st_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;

    logic             locked, ld, smp;
    logic [PAT_W-1:0] shifted;
    logic [FW-1:0]    fill_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit, lock_hit;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q   <= IDLE;
            hist_q <= '0;
            pat_q  <= PATTERN;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            st_q   <= st_d;
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    // Next-state logic
    always_comb begin
        locked   = (st_q == LOCKED);
        ld       = PAT_LD & ~locked;
        smp      = EN & ~PAT_LD & ~locked;
        shifted  = {hist_q[PAT_W-2:0], X};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + CNT_W'(1);
        // The completing bit is the one that brings fill to PAT_W.
        hit      = smp && (fill_inc == FULL) && (shifted == pat_q);
        lock_hit = (LOCK_N != 0) && hit && (cnt_inc == LOCK_AT);

        st_d   = st_q;
        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;

        unique case (1'b1)
            locked: begin
                z_d = 1'b1;
            end
            ld: begin
                pat_d  = PAT_IN;
                fill_d = '0;
                st_d   = (st_q == RUN) ? FILL : IDLE;
            end
            smp: begin
                hist_d = shifted;
                if (hit) begin
                    cnt_d = cnt_inc;
                    z_d   = 1'b1;
                    if (lock_hit) begin
                        fill_d = FULL;
                        st_d   = LOCKED;
                    end else if (OVERLAP) begin
                        fill_d = FULL;
                        st_d   = RUN;
                    end else begin
                        fill_d = '0;
                        st_d   = FILL;
                    end
                end else begin
                    fill_d = fill_inc;
                    st_d   = (fill_inc == FULL) ? RUN : FILL;
                end
            end
            default: begin
            end
        endcase
    end

    // Output logic
    always_comb begin
        Z         = z_q;
        LOCK      = (st_q == LOCKED);
        MATCH_CNT = cnt_q;
        state     = st_q;
    end

endmodule
